// File: rtl/bp_pkg.sv
// Types and constants shared between the branch history table and the branch resolver.
package bp_pkg;

   localparam int BP_HIST_W = 2;

   // 2-bit saturating predictor encodings; the MSB is the predicted direction.
   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   typedef struct packed {
      logic                 valid;
      logic                 taken;
      logic [BP_HIST_W-1:0] hist;
   } bp_upd_t;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } rs_state_e;

endpackage

// File: rtl/pred_fifo.sv
// Circular buffer of in-flight predictions with a synchronous clear that overrides push and pop.
module pred_fifo #(
   parameter  int DEPTH  = 4,
   parameter  int DATA_W = 3,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int OCC_W  = PTR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clr,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_din,
   output logic [DATA_W-1:0] o_dout,
   output logic [OCC_W-1:0]  o_count,
   output logic              o_full,
   output logic              o_empty
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [OCC_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;

   assign o_full  = (r_count == OCC_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_dout  = r_mem[r_rptr];
   assign o_count = r_count;

   // Storage carries no reset; occupancy and pointers alone define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_din;
      end
   end

   // Pointers are exactly log2(DEPTH) bits, so increments wrap modulo DEPTH.
   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + OCC_W'(1);
            2'b01:   r_count <= r_count - OCC_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Matches execute-stage outcomes against queued fetch predictions, trains the BHT and flushes on mispredict.
module branch_resolver
   import bp_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int HIST_W = BP_HIST_W,
   parameter  int CNT_W  = 8,
   localparam int PEND_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pred_valid,
   input  logic              pred_taken,
   input  logic [HIST_W-1:0] pred_hist,
   output logic              pred_ready,
   input  logic              res_valid,
   input  logic              res_taken,
   output logic              upd_valid,
   output logic              upd_taken,
   output logic [HIST_W-1:0] upd_hist,
   output logic              mispredict,
   output logic [PEND_W-1:0] pending,
   output logic [CNT_W-1:0]  correct_cnt,
   output logic [CNT_W-1:0]  mispred_cnt,
   output logic              proto_err
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   rs_state_e         r_state;
   logic              r_upd_valid;
   logic              r_upd_taken;
   logic [HIST_W-1:0] r_upd_hist;
   logic              r_mispredict;
   logic [CNT_W-1:0]  r_correct_cnt;
   logic [CNT_W-1:0]  r_mispred_cnt;
   logic              r_proto_err;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_res;
   logic              w_mis;
   logic [HIST_W:0]   w_head;
   logic              w_head_taken;
   logic [HIST_W-1:0] w_head_hist;

   assign pred_ready   = (r_state == ST_RUN) && !w_full;
   assign w_push       = pred_valid && pred_ready;
   assign w_res        = res_valid && !w_empty;
   assign w_head_taken = w_head[HIST_W];
   assign w_head_hist  = w_head[HIST_W-1:0];
   assign w_mis        = w_res && (w_head_taken != res_taken);

   // A mispredict clears the queue; the clear also discards any same-cycle wrong-path push.
   pred_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (HIST_W + 1)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_mis),
      .i_push  (w_push),
      .i_pop   (w_res),
      .i_din   ({pred_taken, pred_hist}),
      .o_dout  (w_head),
      .o_count (pending),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_RUN;
      end else begin
         case (r_state)
            ST_RUN:   r_state <= w_mis ? ST_FLUSH : ST_RUN;
            ST_FLUSH: r_state <= ST_RUN;
            default:  r_state <= ST_RUN;
         endcase
      end
   end

   // Update strobe, flush pulse and statistics all land on the edge after the resolve.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_upd_valid   <= 1'b0;
         r_upd_taken   <= 1'b0;
         r_upd_hist    <= '0;
         r_mispredict  <= 1'b0;
         r_correct_cnt <= '0;
         r_mispred_cnt <= '0;
         r_proto_err   <= 1'b0;
      end else begin
         r_upd_valid  <= w_res;
         r_mispredict <= w_mis;
         if (w_res) begin
            r_upd_taken <= res_taken;
            r_upd_hist  <= w_head_hist;
            if (w_mis) begin
               r_mispred_cnt <= sat_inc(r_mispred_cnt);
            end else begin
               r_correct_cnt <= sat_inc(r_correct_cnt);
            end
         end
         if (res_valid && w_empty) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   assign upd_valid   = r_upd_valid;
   assign upd_taken   = r_upd_taken;
   assign upd_hist    = r_upd_hist;
   assign mispredict  = r_mispredict;
   assign correct_cnt = r_correct_cnt;
   assign mispred_cnt = r_mispred_cnt;
   assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios then random traffic, scored against a queue-based model.
module tb_branch_resolver;

   localparam int DEPTH  = 4;
   localparam int HIST_W = 2;
   localparam int CNT_W  = 2;
   localparam int PEND_W = 3;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              pred_valid;
   logic              pred_taken;
   logic [HIST_W-1:0] pred_hist;
   logic              pred_ready;
   logic              res_valid;
   logic              res_taken;
   logic              upd_valid;
   logic              upd_taken;
   logic [HIST_W-1:0] upd_hist;
   logic              mispredict;
   logic [PEND_W-1:0] pending;
   logic [CNT_W-1:0]  correct_cnt;
   logic [CNT_W-1:0]  mispred_cnt;
   logic              proto_err;

   always #5 clk = ~clk;

   branch_resolver #(
      .DEPTH  (DEPTH),
      .HIST_W (HIST_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pred_valid  (pred_valid),
      .pred_taken  (pred_taken),
      .pred_hist   (pred_hist),
      .pred_ready  (pred_ready),
      .res_valid   (res_valid),
      .res_taken   (res_taken),
      .upd_valid   (upd_valid),
      .upd_taken   (upd_taken),
      .upd_hist    (upd_hist),
      .mispredict  (mispredict),
      .pending     (pending),
      .correct_cnt (correct_cnt),
      .mispred_cnt (mispred_cnt),
      .proto_err   (proto_err)
   );

   typedef struct { int t; int h; } ent_t;
   typedef struct { int h; int t; int mis; int cc; int mc; } exp_t;

   ent_t mq[$];
   exp_t sb[$];
   int   m_cc, m_mc, m_proto, m_flush, known, after_rst;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock of stimulus; the model advances by the same rules the DUT must follow.
   task automatic cycle(input int rst, input int pv, input int pt, input int ph,
                        input int rv, input int rt);
      int   ready;
      int   nf;
      ent_t e;
      exp_t x;
      @(negedge clk);
      reset      = rst[0];
      pred_valid = pv[0];
      pred_taken = pt[0];
      pred_hist  = HIST_W'(ph);
      res_valid  = rv[0];
      res_taken  = rt[0];
      #1;
      ready = (mq.size() < DEPTH && m_flush == 0) ? 1 : 0;
      if (known != 0) begin
         chk("pred_ready", int'(pred_ready), ready);
         chk("pending", int'(pending), mq.size());
         chk("correct_cnt", int'(correct_cnt), m_cc);
         chk("mispred_cnt", int'(mispred_cnt), m_mc);
         chk("proto_err", int'(proto_err), m_proto);
         if (after_rst != 0) begin
            chk("rst_upd_valid", int'(upd_valid), 0);
            chk("rst_upd_taken", int'(upd_taken), 0);
            chk("rst_upd_hist", int'(upd_hist), 0);
            chk("rst_mispredict", int'(mispredict), 0);
         end
      end
      nf = 0;
      if (rst != 0) begin
         mq.delete();
         m_cc = 0; m_mc = 0; m_proto = 0;
         known = 1;
      end else begin
         if (rv != 0 && mq.size() == 0) m_proto = 1;
         if (rv != 0 && mq.size() > 0) begin
            e     = mq.pop_front();
            x.h   = e.h;
            x.t   = rt;
            x.mis = (e.t != rt) ? 1 : 0;
            if (x.mis != 0) begin
               if (m_mc < CMAX) m_mc++;
               mq.delete();
               nf = 1;
            end else begin
               if (m_cc < CMAX) m_cc++;
               if (pv != 0 && ready != 0) mq.push_back('{pt, ph});
            end
            x.cc = m_cc;
            x.mc = m_mc;
            sb.push_back(x);
         end else if (pv != 0 && ready != 0) begin
            mq.push_back('{pt, ph});
         end
      end
      m_flush   = nf;
      after_rst = rst;
   endtask

   // Monitor: every update the DUT presents must match the oldest expected one.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (known != 0) begin
            if (upd_valid === 1'b1) begin
               if (sb.size() == 0) begin
                  chk("upd_unexpected", 1, 0);
               end else begin
                  x = sb.pop_front();
                  chk("upd_hist", int'(upd_hist), x.h);
                  chk("upd_taken", int'(upd_taken), x.t);
                  chk("upd_mispredict", int'(mispredict), x.mis);
                  chk("upd_correct_cnt", int'(correct_cnt), x.cc);
                  chk("upd_mispred_cnt", int'(mispred_cnt), x.mc);
               end
            end else begin
               chk("idle_mispredict", int'(mispredict), 0);
            end
         end
      end
   end

   initial begin
      int pv, rv, rt;
      known = 0; after_rst = 0; m_flush = 0;
      m_cc = 0; m_mc = 0; m_proto = 0;
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);

      // single correct taken prediction at hist 1
      cycle(0, 1, 1, 1, 0, 0);
      cycle(0, 0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 0, 0);

      // fill to DEPTH, offer a fifth, then drain correctly (counter saturates)
      for (int i = 0; i < 4; i++) cycle(0, 1, i & 1, i, 0, 0);
      cycle(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, i & 1);
      cycle(0, 0, 0, 0, 0, 0);

      // three in flight, head mispredicts, push offered during flush
      cycle(0, 1, 1, 2, 0, 0);
      cycle(0, 1, 1, 3, 0, 0);
      cycle(0, 1, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 1, 1, 1, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);

      // same-cycle push and mispredicting resolve with two pending
      cycle(0, 1, 0, 1, 0, 0);
      cycle(0, 1, 0, 2, 0, 0);
      cycle(0, 1, 0, 3, 1, 1);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);

      // resolve while empty
      cycle(0, 0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);

      // reset with branches in flight and a resolve presented
      cycle(0, 1, 1, 1, 0, 0);
      cycle(0, 1, 0, 2, 0, 0);
      cycle(1, 1, 1, 3, 1, 1);
      cycle(0, 0, 0, 0, 0, 0);

      for (int n = 0; n < 600; n++) begin
         pv = ($urandom_range(0, 99) < 55) ? 1 : 0;
         rv = ($urandom_range(0, 99) < 40) ? 1 : 0;
         if (mq.size() > 0 && $urandom_range(0, 3) != 0) rt = mq[0].t;
         else rt = $urandom_range(0, 1);
         cycle(($urandom_range(0, 149) == 0) ? 1 : 0, pv, $urandom_range(0, 1),
               $urandom_range(0, 3), rv, rt);
      end

      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      chk("scoreboard_drain", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
